// File: rtl/pid_pwm_pkg.sv
// Shared types and constants for the PID PWM driver slice.
// Holds the driver FSM encoding, the counter terminal value and the duty width.
package pid_pwm_pkg;

    localparam int DUTY_W = 8;
    localparam logic [7:0] PWM_MAX_CNT = 8'd254;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pid_pwm_driver_if.sv
// Duty-update handshake between the PID controller (master) and the PWM driver (slave).
interface pid_pwm_driver_if;
    import pid_pwm_pkg::*;

    logic [DUTY_W-1:0] duty_in;
    logic              duty_valid;
    logic              duty_ready;

    modport master (output duty_in, output duty_valid, input duty_ready);
    modport slave  (input duty_in, input duty_valid, output duty_ready);
endinterface

// File: rtl/pid_slew_step.sv
// One slew-limited step from the current duty toward the target duty.
// The difference is taken as 9-bit signed so 0<->255 moves never wrap.
module pid_slew_step
    import pid_pwm_pkg::*;
#(
    parameter int SLEW_MAX = 16
) (
    input  logic [DUTY_W-1:0] cur_duty,
    input  logic [DUTY_W-1:0] tgt_duty,
    output logic [DUTY_W-1:0] next_duty
);

    localparam logic [8:0] SLEW_L = 9'(SLEW_MAX);

    logic signed [8:0] diff_s;
    logic        [8:0] mag_s;

    // Clamp the requested move to +/-SLEW_MAX (0 means jump straight to target)
    always_comb begin
        diff_s = $signed({1'b0, tgt_duty}) - $signed({1'b0, cur_duty});
        mag_s  = diff_s[8] ? $unsigned(-diff_s) : $unsigned(diff_s);
        if ((SLEW_MAX == 32'sd0) || (mag_s <= SLEW_L)) begin
            next_duty = tgt_duty;
        end else if (diff_s[8]) begin
            next_duty = cur_duty - SLEW_L[7:0];
        end else begin
            next_duty = cur_duty + SLEW_L[7:0];
        end
    end

endmodule

// File: rtl/pid_pwm_driver.sv
// PWM actuator driver: double-buffered, slew-limited duty applied at period starts,
// with a period-start tick used as the PID sample strobe.
module pid_pwm_driver
    import pid_pwm_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int SLEW_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    pid_pwm_driver_if.slave   duty_if,
    output logic              pwm_out,
    output logic              period_tick,
    output logic [DUTY_W-1:0] duty_active,
    output logic              running
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    pwm_state_e        state_r;
    logic [PW-1:0]     pre_cnt_r;
    logic [7:0]        cnt_r;
    logic [DUTY_W-1:0] pend_r;
    logic              pend_full_r;
    logic [DUTY_W-1:0] target_r;
    logic [DUTY_W-1:0] duty_active_r;
    logic              pwm_r;
    logic              tick_r;
    logic              running_r;

    logic              step_s;
    logic              wrap_s;
    logic              accept_s;
    logic              ps_s;
    logic [DUTY_W-1:0] new_tgt_s;
    logic [DUTY_W-1:0] slew_duty_s;

    assign step_s    = (pre_cnt_r == PRE_LAST);
    assign wrap_s    = step_s && (cnt_r == PWM_MAX_CNT);
    assign accept_s  = duty_if.duty_valid && !pend_full_r;
    assign new_tgt_s = pend_full_r ? pend_r : target_r;

    assign duty_if.duty_ready = ~pend_full_r;
    assign pwm_out            = pwm_r;
    assign period_tick        = tick_r;
    assign duty_active        = duty_active_r;
    assign running            = running_r;

    // Period-start decision: enable from IDLE, or a wrap that stays in RUN
    always_comb begin
        ps_s = 1'b0;
        case (state_r)
            IDLE:     ps_s = enable;
            RUN:      ps_s = wrap_s;
            STOPPING: ps_s = wrap_s && enable;
            default:  ps_s = 1'b0;
        endcase
    end

    pid_slew_step #(.SLEW_MAX(SLEW_MAX)) u_slew (
        .cur_duty  (duty_active_r),
        .tgt_duty  (new_tgt_s),
        .next_duty (slew_duty_s)
    );

    // Single-entry pending slot; an accept can only happen while it is empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r      <= 8'd0;
            pend_full_r <= 1'b0;
        end else if (accept_s) begin
            pend_r      <= duty_if.duty_in;
            pend_full_r <= 1'b1;
        end else if (ps_s && pend_full_r) begin
            pend_full_r <= 1'b0;
        end
    end

    // Driver FSM with counters, duty registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            pre_cnt_r     <= '0;
            cnt_r         <= 8'd0;
            target_r      <= 8'd0;
            duty_active_r <= 8'd0;
            pwm_r         <= 1'b0;
            tick_r        <= 1'b0;
            running_r     <= 1'b0;
        end else begin
            tick_r <= ps_s;
            pwm_r  <= (state_r != IDLE) && (cnt_r < duty_active_r);
            if (ps_s) begin
                target_r      <= new_tgt_s;
                duty_active_r <= slew_duty_s;
            end
            case (state_r)
                IDLE: begin
                    pre_cnt_r <= '0;
                    cnt_r     <= 8'd0;
                    if (enable) begin
                        state_r   <= RUN;
                        running_r <= 1'b1;
                    end else begin
                        state_r   <= IDLE;
                        running_r <= 1'b0;
                    end
                end
                RUN, STOPPING: begin
                    if (step_s) begin
                        pre_cnt_r <= '0;
                        cnt_r     <= wrap_s ? 8'd0 : cnt_r + 8'd1;
                    end else begin
                        pre_cnt_r <= pre_cnt_r + 1'b1;
                    end
                    // A stop completes at the wrap: duty and target fall back to 0, pend is kept
                    if (wrap_s && (state_r == STOPPING) && !enable) begin
                        state_r       <= IDLE;
                        running_r     <= 1'b0;
                        duty_active_r <= 8'd0;
                        target_r      <= 8'd0;
                    end else if (enable) begin
                        state_r   <= RUN;
                        running_r <= 1'b1;
                    end else begin
                        state_r   <= STOPPING;
                        running_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    running_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pid_pwm_driver.sv
// Scoreboard bench for pid_pwm_driver: a period-level reference model predicts
// duty at every period start and per-cycle pwm/ready/running levels.
module tb_pid_pwm_driver;

    localparam int P   = 2;
    localparam int S   = 16;
    localparam int PER = 255 * P;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       enable = 1'b0;
    logic       pwm_out;
    logic       period_tick;
    logic       running;
    logic [7:0] duty_active;

    pid_pwm_driver_if dif ();

    pid_pwm_driver #(.PRESCALE(P), .SLEW_MAX(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .duty_if     (dif.slave),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .duty_active (duty_active),
        .running     (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        int duty;
        bit chk;
    } exp_t;

    exp_t sb_q[$];
    int   send_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state: 0 idle, 1 run, 2 stopping; pos = cycles since last period start
    int m_st = 0, m_pos = 0, m_pend = 0, m_tgt = 0, m_act = 0, m_ps_cnt = 0;
    bit m_full = 1'b0, m_acc = 1'b0, m_pwm = 1'b0;

    int   mon_cyc = 0, mon_last = 0;
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    // one clock: advance the model for the coming edge, then compare after it
    task automatic step();
        bit   wrap;
        bit   ps;
        int   diff;
        exp_t e;
        m_pwm = (m_st != 0) && ((m_pos / P) < m_act);
        m_acc = dif.duty_valid && !m_full;
        wrap  = (m_st != 0) && (m_pos == PER - 1);
        ps    = (m_st == 0 && enable) || (wrap && (m_st == 1 || enable));
        if (ps) begin
            if (m_full) begin
                m_tgt  = m_pend;
                m_full = 1'b0;
            end
            diff = m_tgt - m_act;
            if (S == 0 || (diff <= S && diff >= -S)) m_act = m_tgt;
            else m_act = m_act + ((diff > 0) ? S : -S);
            e.duty = m_act;
            e.chk  = (m_st != 0);
            sb_q.push_back(e);
            m_ps_cnt++;
            m_pos = 0;
            m_st  = enable ? 1 : 2;
        end else if (wrap) begin
            m_st  = 0;
            m_act = 0;
            m_tgt = 0;
            m_pos = 0;
        end else if (m_st != 0) begin
            m_pos++;
            m_st = enable ? 1 : 2;
        end
        if (m_acc) begin
            m_pend = dif.duty_in;
            m_full = 1'b1;
        end
        @(posedge clk);
        #1;
        check("pwm_out", pwm_out, m_pwm);
        check("duty_ready", dif.duty_ready, !m_full);
        check("running", running, m_st != 0);
        check("duty_active", duty_active, m_act);
        if (m_acc) begin
            if (send_q.size() > 0) dif.duty_in = 8'(send_q.pop_front());
            else dif.duty_valid = 1'b0;
        end
    endtask

    task automatic send(input int v);
        if (!dif.duty_valid) begin
            dif.duty_in    = 8'(v);
            dif.duty_valid = 1'b1;
        end else begin
            send_q.push_back(v);
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_ps(input int n);
        int tgt    = m_ps_cnt + n;
        int budget = n * PER + PER + 16;
        while (m_ps_cnt < tgt && budget > 0) begin
            step();
            budget--;
        end
    endtask

    task automatic run_until_pos(input int p);
        int budget = 2 * PER;
        while (!(m_st == 1 && m_pos == p) && budget > 0) begin
            step();
            budget--;
        end
    endtask

    // async reset mid-cycle: outputs must clear at once, model and queues restart
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_pwm_out", pwm_out, 0);
        check("rst_period_tick", period_tick, 0);
        check("rst_duty_active", duty_active, 0);
        check("rst_running", running, 0);
        check("rst_duty_ready", dif.duty_ready, 1);
        m_st = 0; m_pos = 0; m_pend = 0; m_tgt = 0; m_act = 0; m_full = 1'b0;
        sb_q.delete();
        send_q.delete();
        dif.duty_valid = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // monitor: pop the expectation whenever the DUT presents a period tick
    initial begin
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (period_tick === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("tick_unexpected", period_tick, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("duty_at_ps", duty_active, mon_e.duty);
                    if (mon_e.chk) check("tick_gap", mon_cyc - mon_last, PER);
                end
                mon_last = mon_cyc;
            end
        end
    end

    initial begin
        dif.duty_in    = 8'd0;
        dif.duty_valid = 1'b0;
        do_reset();

        // preload in IDLE, then run up to 64
        send(64);
        run(4);
        enable = 1'b1;
        run_ps(5);
        check("t1_duty64", duty_active, 64);

        // extremes
        send(0);
        run_ps(8);
        send(255);
        run_ps(19);
        check("t3_duty255", duty_active, 255);

        // reset mid-period with a pending value, which must be discarded
        send(77);
        run(40);
        do_reset();
        enable = 1'b1;
        run(3);
        check("rst_pend_dropped", duty_active, 0);

        // slew ramp toward 100, then a small step to 90
        send(100);
        run_ps(8);
        check("t4_duty100", duty_active, 100);
        send(90);
        run_ps(2);

        // back-to-back updates within one period
        send(10);
        send(20);
        run_ps(4);

        // drop enable at cnt=100, finish the period, settle in IDLE
        run_until_pos(100 * P);
        enable = 1'b0;
        run(PER + 60);
        check("t6_idle_duty", duty_active, 0);

        // randomized updates and enable toggles
        enable = 1'b1;
        repeat (14) begin
            case ($urandom_range(0, 3))
                0: send($urandom_range(0, 255));
                1: run($urandom_range(1, 600));
                2: begin
                    enable = 1'b0;
                    run($urandom_range(1, 400));
                    enable = 1'b1;
                    run($urandom_range(1, 50));
                end
                default: begin
                    send($urandom_range(0, 255));
                    send($urandom_range(0, 255));
                    run($urandom_range(100, 700));
                end
            endcase
        end
        enable = 1'b1;
        run_ps(2);

        @(negedge clk);
        #1;
        check("sb_drain", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pid_pwm_driver.md
Name: pid_pwm_driver

Overview:
- Downstream stage of the PID controller. Consumes the 8-bit controller output (control_out) through a valid/ready handshake.
- Drives a single-ended PWM actuator output.
- Double-buffers duty updates so they apply only at period boundaries, and slew-limits each change.
- Emits a period-start tick that the PID loop uses as its sample strobe.

Parameters:
- PRESCALE, 4: clk cycles per PWM count step (>=1).
- SLEW_MAX, 16: max |duty change| per period. 0 = unlimited (jump straight to target).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- enable  in  1  run request; level-sensitive
- duty_in  in  8  requested duty (0..255), from PID control_out
- duty_valid  in  1  duty_in valid
- duty_ready  out  1  pending slot empty; transfer when valid&ready
- pwm_out  out  1  PWM output, registered
- period_tick  out  1  1-cycle pulse at each period start
- duty_active  out  8  duty currently applied
- running  out  1  high in RUN or STOPPING

Behaviour:
- Reset rst_n: asynchronous, active-low. Clock clk: all state on posedge clk.
- Reset values:
  - pwm_out=0, period_tick=0, duty_active=0, running=0, duty_ready=1.
  - pending empty, target=0, counters=0, state=IDLE.
- Counters:
  - pre_cnt counts 0..PRESCALE-1. Step event = pre_cnt==PRESCALE-1.
  - cnt counts 0..254 and advances on each step event.
  - Period = 255*PRESCALE clk cycles.
  - Wrap event = step event with cnt==254.
- PWM compare:
  - pwm_out <= (cnt < duty_active) in RUN/STOPPING; otherwise 0.
  - One cycle of latency vs cnt/duty_active.
  - Duty 0 gives never high. Duty 255 gives always high with no glitch at the wrap.
- Handshake:
  - Accept when duty_valid&duty_ready: pend<=duty_in, pend_full<=1, so duty_ready drops the next cycle.
  - duty_valid is held by the source until accepted.
  - Accepting is allowed in every state, including IDLE (preload).
- Period start (PS): the cycle of the IDLE->RUN transition, and every wrap event in RUN.
  - At each PS, if pend_full: target<=pend and pend_full<=0.
  - At each PS, step duty_active toward the updated target:
    - diff = target - duty_active, as 9-bit signed.
    - |diff|<=SLEW_MAX or SLEW_MAX==0: duty_active<=target.
    - Otherwise: duty_active += SLEW_MAX*sign(diff).
  - At each PS, period_tick<=1 for exactly one cycle.
  - Accept and PS in the same cycle (slot empty at PS): the accepted value goes to pend and transfers at the next PS.
- State machine:
  - IDLE: counters held at 0, duty_active=0, target=0.
    - enable=1 -> RUN, with cnt=0, pre_cnt=0, and the PS actions applied.
  - RUN:
    - enable=0 -> STOPPING.
  - STOPPING: continues the current period with no PS actions and no tick.
    - At the wrap event -> IDLE, with duty_active<=0 and target<=0; pend is kept.
    - If enable re-asserts before the wrap, go back to RUN; that wrap is then a normal PS.
- Reset mid-operation: immediate return to reset values. Any pending value is discarded.
- Arithmetic:
  - Unsigned 8-bit duty.
  - Slew computed in 9-bit signed, so no overflow at 0/255.

Decomposition:
- Package pid_pwm_pkg holds:
  - the state enum (IDLE, RUN, STOPPING);
  - PWM_MAX_CNT=254;
  - the duty width constant (8).
- Sub-module pid_slew_step: combinational. Inputs current, target and SLEW_MAX; output next duty. Instantiated once.
- Prescaler, counter, handshake register and FSM stay in the top.

Test Plan:
1. Preload and enable (PRESCALE=1, SLEW_MAX=0): accept 64 in IDLE, then raise enable.
   - period_tick in the enable cycle and every 255 cycles.
   - duty_active=64.
   - pwm_out high 64 / low 191 cycles per period.
2. Duty extremes: duty 0.
   - pwm_out constantly 0 over 3 periods.
3. Duty extremes: duty 255.
   - pwm_out constantly 1 over 3 periods, including across the wrap.
4. Slew (SLEW_MAX=16): from duty_active 0, load 100.
   - Successive PS values: 16, 32, 48, 64, 80, 96, 100.
   - Then load 90: next PS gives 90.
5. Handshake: duty_valid held with 10 then 20, back-to-back within one period.
   - 10 accepted; duty_ready=0 until the next PS.
   - 20 accepted the cycle after that PS.
   - duty_active=10 for that period, 20 the following one.
6. Stop and reset:
   - Drop enable at cnt=100: pwm continues to the wrap, then IDLE. pwm_out=0, duty_active=0, no further ticks, running=0.
   - Separately, assert rst_n low mid-period: all outputs go to reset values immediately and a pending value is discarded.
